// File: rtl/mux_dff_stage_pkg.sv
// Shared types for the mux_dff_stage slice: input-mux select encoding and its decode.
package mux_dff_stage_pkg;

    typedef enum logic [1:0] {
        SEL_HOLD  = 2'd0,
        SEL_SHIFT = 2'd1,
        SEL_LOAD  = 2'd2
    } sel_e;

    // Load outranks shift; with neither asserted the slice recirculates its own value.
    function automatic sel_e decode_sel(input logic load, input logic enable);
        sel_e sel;
        sel = SEL_HOLD;
        if (load) begin
            sel = SEL_LOAD;
        end else if (enable) begin
            sel = SEL_SHIFT;
        end
        return sel;
    endfunction

endpackage

// File: rtl/mux_dff_stage_mux.sv
// Two-level input multiplexer feeding the slice flip-flop (combinational).
module mux_dff_stage_mux
    import mux_dff_stage_pkg::*;
#(
    parameter int unsigned WIDTH = 1
) (
    input  logic             load,
    input  logic             enable,
    input  logic [WIDTH-1:0] q,
    input  logic [WIDTH-1:0] w,
    input  logic [WIDTH-1:0] r,
    output logic [WIDTH-1:0] d_c
);

    sel_e sel_c;

    always_comb begin
        sel_c = decode_sel(load, enable);
        d_c   = q;
        unique case (sel_c)
            SEL_LOAD:  d_c = r;
            SEL_SHIFT: d_c = w;
            SEL_HOLD:  d_c = q;
            default:   d_c = q;
        endcase
    end

endmodule

// File: rtl/mux_dff_stage.sv
// One loadable, enable-gated shift-register slice; Q comes straight from the flip-flop.
module mux_dff_stage
    import mux_dff_stage_pkg::*;
#(
    parameter int unsigned WIDTH = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] w,
    input  logic [WIDTH-1:0] R,
    input  logic             E,
    input  logic             L,
    output logic [WIDTH-1:0] Q
);

    logic [WIDTH-1:0] q_r;
    logic [WIDTH-1:0] d_c;

    mux_dff_stage_mux #(
        .WIDTH (WIDTH)
    ) u_mux (
        .load   (L),
        .enable (E),
        .q      (q_r),
        .w      (w),
        .r      (R),
        .d_c    (d_c)
    );

    // Reset sits ahead of the mux so it wins over load and shift.
    always_ff @(posedge clk) begin
        if (reset) begin
            q_r <= '0;
        end else begin
            q_r <= d_c;
        end
    end

    assign Q = q_r;

endmodule

// File: tb/tb_mux_dff_stage.sv
// Directed and random checks of mux_dff_stage against a priority model of the slice.
module tb_mux_dff_stage;

    localparam int unsigned W = 4;
    localparam logic [W-1:0] ONES = '1;

    logic         clk;
    logic         reset;
    logic [W-1:0] w;
    logic [W-1:0] r;
    logic         e;
    logic         l;
    logic [W-1:0] q;

    logic [W-1:0] exp_q;
    int           total;
    int           bad;

    mux_dff_stage #(
        .WIDTH (W)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .w     (w),
        .R     (r),
        .E     (e),
        .L     (l),
        .Q     (q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Apply the slice rules to the inputs present at the rising edge.
    task automatic model_edge();
        if (reset)  exp_q = '0;
        else if (l) exp_q = r;
        else if (e) exp_q = w;
    endtask

    task automatic check(input string tag);
        total++;
        assert (q === exp_q)
        else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, q, exp_q);
        end
    endtask

    // Rising edge: update model from sampled inputs, then check just after.
    task automatic rise(input string tag);
        @(posedge clk);
        model_edge();
        #1;
        check(tag);
    endtask

    // Falling edge: Q must not move.
    task automatic fall(input string tag);
        @(negedge clk);
        #1;
        check(tag);
    endtask

    initial begin
        total = 0;
        bad   = 0;
        exp_q = 'x;

        // Reset beats load
        reset = 1'b1; l = 1'b1; e = 1'b0; r = ONES; w = '0;
        rise("reset_over_load");
        fall("reset_fall");
        reset = 1'b0; l = 1'b0; e = 1'b0;
        rise("idle_after_reset");

        // Load priority over shift
        fall("pre_load1");
        l = 1'b1; e = 1'b1; r = ONES; w = '0;
        rise("load_ones");
        fall("pre_load0");
        r = '0; w = ONES;
        rise("load_zeros");

        // Shift
        fall("pre_shift1");
        l = 1'b0; e = 1'b1; w = ONES;
        rise("shift_ones");
        fall("pre_shift0");
        w = 4'h5;
        rise("shift_pattern");

        // Hold with w/R toggling every half-cycle
        fall("pre_hold_load");
        l = 1'b1; e = 1'b0; r = ONES;
        rise("hold_load");
        l = 1'b0; e = 1'b0; w = '0; r = '0;
        for (int i = 0; i < 5; i++) begin
            fall("hold_fall");
            w = ~w; r = ~r;
            rise("hold_rise");
            w = ~w; r = ~r;
        end

        // Mid-sequence reset with load and shift both active
        fall("pre_mid_reset");
        reset = 1'b1; l = 1'b1; e = 1'b1; r = ONES; w = ONES;
        rise("mid_reset");
        reset = 1'b0; l = 1'b0; e = 1'b1; w = 4'hA;
        rise("resume_shift");

        // Random half-cycle vectors; inputs change just after each edge
        for (int i = 0; i < 200; i++) begin
            reset = ($urandom_range(0, 15) == 0);
            l     = 1'($urandom);
            e     = 1'($urandom);
            w     = W'($urandom);
            r     = W'($urandom);
            if (i % 2 == 0) fall("rand_fall");
            else            rise("rand_rise");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Watchdog against a stalled clock.
    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
